// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2**HIST_W saturating counters indexed by pc ^ history.
// Optional macro GSHARE_PHT_FWD_EN forwards a same-cycle same-index train into the lookup.
module gshare_pht #(
  parameter int HIST_W = 7,
  parameter int PC_W   = 7,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              predict_valid,
  input  logic [PC_W-1:0]   predict_pc,
  input  logic [HIST_W-1:0] predict_history,
  output logic              resp_valid,
  output logic              resp_taken,
  output logic [HIST_W-1:0] resp_index,
  input  logic              train_valid,
  input  logic              train_taken,
  input  logic [PC_W-1:0]   train_pc,
  input  logic [HIST_W-1:0] train_history
);

  localparam int DEPTH = 2 ** HIST_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = '0;
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : CNT_W'(c + 1'b1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == CNT_MIN) ? c : CNT_W'(c - 1'b1);
  endfunction

  logic [CNT_W-1:0]  cnt_q [DEPTH];
  logic [CNT_W-1:0]  cnt_d [DEPTH];
  logic              resp_valid_q, resp_valid_d;
  logic              resp_taken_q, resp_taken_d;
  logic [HIST_W-1:0] resp_index_q, resp_index_d;

  logic [HIST_W-1:0] pred_idx;
  logic [HIST_W-1:0] train_idx;
  logic [CNT_W-1:0]  lookup_cnt;

  // PC_W is required to equal HIST_W, so the XOR is width-exact.
  assign pred_idx  = predict_pc ^ predict_history;
  assign train_idx = train_pc ^ train_history;

  always_comb begin
    cnt_d = cnt_q;
    if (train_valid) begin
      cnt_d[train_idx] = train_taken ? sat_inc(cnt_q[train_idx])
                                     : sat_dec(cnt_q[train_idx]);
    end

`ifdef GSHARE_PHT_FWD_EN
    lookup_cnt = cnt_d[pred_idx];
`else
    lookup_cnt = cnt_q[pred_idx];
`endif

    resp_valid_d = predict_valid;
    resp_taken_d = resp_taken_q;
    resp_index_d = resp_index_q;
    if (predict_valid) begin
      resp_taken_d = lookup_cnt[CNT_W-1];
      resp_index_d = pred_idx;
    end
  end

  // Lookup -> response register stage; reset also clears the whole table.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_index_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_index_q <= resp_index_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_taken = resp_taken_q;
  assign resp_index = resp_index_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed testbench for gshare_pht: hand-computed lookups, training and saturation.
module tb_gshare_pht;

  logic       clk = 1'b0;
  logic       resetn;
  logic       predict_valid;
  logic [6:0] predict_pc;
  logic [6:0] predict_history;
  logic       resp_valid;
  logic       resp_taken;
  logic [6:0] resp_index;
  logic       train_valid;
  logic       train_taken;
  logic [6:0] train_pc;
  logic [6:0] train_history;

  int vectors = 0;
  int miscompares = 0;

  gshare_pht #(.HIST_W(7), .PC_W(7), .CNT_W(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .predict_valid  (predict_valid),
    .predict_pc     (predict_pc),
    .predict_history(predict_history),
    .resp_valid     (resp_valid),
    .resp_taken     (resp_taken),
    .resp_index     (resp_index),
    .train_valid    (train_valid),
    .train_taken    (train_taken),
    .train_pc       (train_pc),
    .train_history  (train_history)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [6:0] pc, input logic [6:0] hist);
    predict_valid = 1'b1; predict_pc = pc; predict_history = hist;
    tick();
    predict_valid = 1'b0;
  endtask

  task automatic train(input logic [6:0] pc, input logic [6:0] hist, input logic tk);
    train_valid = 1'b1; train_taken = tk; train_pc = pc; train_history = hist;
    tick();
    train_valid = 1'b0;
  endtask

  logic exp_fwd;

  initial begin
    resetn = 1'b0; predict_valid = 1'b0; predict_pc = '0; predict_history = '0;
    train_valid = 1'b0; train_taken = 1'b0; train_pc = '0; train_history = '0;
    tick(); tick();
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_taken", 32'(resp_taken), 32'd0);
    check("rst_index", 32'(resp_index), 32'd0);
    resetn = 1'b1;
    tick();

    lookup(7'h05, 7'h00);
    check("lk05_valid", 32'(resp_valid), 32'd1);
    check("lk05_taken", 32'(resp_taken), 32'd0);
    check("lk05_index", 32'(resp_index), 32'h05);
    tick();
    check("idle_valid", 32'(resp_valid), 32'd0);

    train(7'h03, 7'h01, 1'b1);
    lookup(7'h02, 7'h00);
    check("lk02_valid", 32'(resp_valid), 32'd1);
    check("lk02_taken", 32'(resp_taken), 32'd1);
    check("lk02_index", 32'(resp_index), 32'h02);

    for (int i = 0; i < 4; i++) train(7'h10, 7'h00, 1'b1);
    train(7'h10, 7'h00, 1'b0);
    lookup(7'h00, 7'h10);
    check("lk10_sat_hi", 32'(resp_taken), 32'd1);
    check("lk10_index", 32'(resp_index), 32'h10);
    train(7'h10, 7'h00, 1'b0);
    lookup(7'h10, 7'h00);
    check("lk10_after_dec2", 32'(resp_taken), 32'd0);

    for (int i = 0; i < 3; i++) train(7'h7F, 7'h00, 1'b0);
    lookup(7'h7F, 7'h00);
    check("lk7f_sat_lo", 32'(resp_taken), 32'd0);
    train(7'h7F, 7'h00, 1'b1);
    lookup(7'h7F, 7'h00);
    check("lk7f_inc1", 32'(resp_taken), 32'd0);
    train(7'h7F, 7'h00, 1'b1);
    lookup(7'h7F, 7'h00);
    check("lk7f_inc2", 32'(resp_taken), 32'd1);

`ifdef GSHARE_PHT_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    train_valid = 1'b1; train_taken = 1'b1; train_pc = 7'h20; train_history = 7'h00;
    predict_valid = 1'b1; predict_pc = 7'h00; predict_history = 7'h20;
    tick();
    train_valid = 1'b0; predict_valid = 1'b0;
    check("same_idx_taken", 32'(resp_taken), 32'(exp_fwd));
    check("same_idx_index", 32'(resp_index), 32'h20);
    lookup(7'h20, 7'h00);
    check("same_idx_next", 32'(resp_taken), 32'd1);

    train_valid = 1'b1; train_taken = 1'b1; train_pc = 7'h30; train_history = 7'h00;
    predict_valid = 1'b1; predict_pc = 7'h31; predict_history = 7'h00;
    tick();
    train_valid = 1'b0; predict_valid = 1'b0;
    check("diff_idx_taken", 32'(resp_taken), 32'd0);
    check("diff_idx_index", 32'(resp_index), 32'h31);
    lookup(7'h30, 7'h00);
    check("diff_idx_trained", 32'(resp_taken), 32'd1);

    predict_valid = 1'b1; predict_pc = 7'h02; predict_history = 7'h00;
    tick();
    check("pre_rst_valid", 32'(resp_valid), 32'd1);
    check("pre_rst_taken", 32'(resp_taken), 32'd1);
    resetn = 1'b0;
    train_valid = 1'b1; train_taken = 1'b1; train_pc = 7'h05; train_history = 7'h00;
    tick();
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_taken", 32'(resp_taken), 32'd0);
    check("mid_rst_index", 32'(resp_index), 32'd0);
    resetn = 1'b1; predict_valid = 1'b0; train_valid = 1'b0;
    tick();

    lookup(7'h02, 7'h00);
    check("post_rst_02", 32'(resp_taken), 32'd0);
    lookup(7'h10, 7'h00);
    check("post_rst_10", 32'(resp_taken), 32'd0);
    lookup(7'h20, 7'h00);
    check("post_rst_20", 32'(resp_taken), 32'd0);
    lookup(7'h7F, 7'h00);
    check("post_rst_7f", 32'(resp_taken), 32'd0);
    train(7'h05, 7'h00, 1'b1);
    lookup(7'h05, 7'h00);
    check("post_rst_05_inc", 32'(resp_taken), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
